// File: rtl/tc_spi_if.sv
// tc_spi_if: start/word handshake between the sampler and the thermocouple SPI master
interface tc_spi_if #(
    parameter int WORD_SIZE = 16
);
    logic                 ena;
    logic [WORD_SIZE-1:0] win;
    logic [WORD_SIZE-1:0] wout;
    logic                 wstb;

    modport master (output ena, win, input wout, wstb);
    modport slave  (input ena, win, output wout, wstb);
endinterface

// File: rtl/tc_sampler.sv
// tc_sampler: periodic thermocouple frame sequencer, decoder and block averager
module tc_sampler #(
    parameter int WORD_SIZE = 16,
    parameter int PERIOD    = 2_500_000,
    parameter int TIMEOUT   = 64,
    parameter int AVG_LOG2  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_trig,
    tc_spi_if.master    spi,
    output logic [11:0] o_temp,
    output logic        o_temp_vld,
    output logic        o_fault,
    output logic        o_frame_err
);
    localparam int PW = $clog2(PERIOD);
    localparam int TW = $clog2(TIMEOUT);
    localparam int AW = 12 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;

    typedef enum logic [1:0] {WAIT, START, XFER, DECODE} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pcnt;
    logic [TW-1:0] tcnt;
    logic [15:1]   w;
    logic [AW-1:0] acc;
    logic [AW-1:0] sum;
    logic [CW-1:0] cnt;
    logic          stb, tmo, bad, opn, full;

    assign spi.ena = state == START;
    assign spi.win = WORD_SIZE'(0);
    assign stb     = state == XFER && spi.wstb;
    assign tmo     = state == XFER && !spi.wstb && tcnt == TW'(TIMEOUT - 1);
    assign bad     = w[15] | w[1];
    assign opn     = w[2];
    assign sum     = acc + AW'(w[14:3]);
    assign full    = cnt == CW'((1 << AVG_LOG2) - 1);

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= WAIT;
        else       state <= state_nxt;
    end

    // period expiry or trigger launches a transfer; strobe or timeout ends it
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT:    state_nxt = (pcnt == '0 || i_trig) ? START : WAIT;
            START:   state_nxt = XFER;
            XFER:    state_nxt = stb ? DECODE : tmo ? WAIT : XFER;
            DECODE:  state_nxt = WAIT;
            default: state_nxt = WAIT;
        endcase
    end

    // period counter saturates at 0 outside WAIT; the START reload also counts the START cycle itself
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pcnt <= PW'(PERIOD - 1);
            tcnt <= '0;
            w    <= '0;
        end else begin
            pcnt <= (state == START) ? PW'(PERIOD - 2) : (pcnt != '0) ? pcnt - 1'b1 : pcnt;
            tcnt <= (state == START) ? '0 : (state == XFER) ? tcnt + 1'b1 : tcnt;
            if (stb) w <= spi.wout[15:1];
        end
    end

    // frame validation, fault tracking and block averaging of good samples
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc         <= '0;
            cnt         <= '0;
            o_temp      <= '0;
            o_temp_vld  <= 1'b0;
            o_fault     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_temp_vld <= 1'b0;
            if (tmo) o_frame_err <= 1'b1;
            if (state == DECODE) begin
                o_frame_err <= bad;
                if (!bad && opn) begin
                    o_fault <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                end else if (!bad && full) begin
                    o_fault    <= 1'b0;
                    o_temp     <= 12'(sum >> AVG_LOG2);
                    o_temp_vld <= 1'b1;
                    acc        <= '0;
                    cnt        <= '0;
                end else if (!bad) begin
                    o_fault <= 1'b0;
                    acc     <= sum;
                    cnt     <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tc_sampler.sv
// tb_tc_sampler: randomized scoreboard bench with a behavioural SPI master and sample-list reference model
module tb_tc_sampler;
    localparam int PERIOD   = 100;
    localparam int TIMEOUT  = 64;
    localparam int AVG_LOG2 = 2;

    typedef struct {logic [15:0] w; int dly;} frm_t;
    typedef struct {int vld; logic [11:0] temp; logic fault; logic err;} res_t;

    logic        clk = 0;
    logic        rst;
    logic        trig;
    logic [11:0] o_temp;
    logic        o_temp_vld, o_fault, o_frame_err;

    tc_spi_if #(.WORD_SIZE(16)) spi ();

    tc_sampler #(.WORD_SIZE(16), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .AVG_LOG2(AVG_LOG2)) dut (
        .i_clk(clk), .i_rst(rst), .i_trig(trig), .spi(spi),
        .o_temp(o_temp), .o_temp_vld(o_temp_vld), .o_fault(o_fault), .o_frame_err(o_frame_err)
    );

    always #5 clk = ~clk;

    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, last_ena = 0, rel = 0, next_gap = PERIOD;
    frm_t fq[$];
    int   gq[$];
    res_t rq[$];
    int   samp[$];
    logic [11:0] m_temp = '0;
    logic m_fault = 0, m_err = 0;
    bit   sb_on = 1, have_prev = 0;
    int   nv = 0, vt = 0, gp;
    res_t mr;
    frm_t sf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic model(input logic [15:0] w, input int dly, output res_t r);
        int s;
        r.vld = 0;
        if (dly < 1 || dly > TIMEOUT) m_err = 1;
        else if (w[15] || w[1]) m_err = 1;
        else if (w[2]) begin
            m_fault = 1; m_err = 0; samp.delete();
        end else begin
            m_fault = 0; m_err = 0;
            samp.push_back(int'(w[14:3]));
            if (samp.size() == (1 << AVG_LOG2)) begin
                s = 0;
                foreach (samp[i]) s += samp[i];
                m_temp = 12'(s / (1 << AVG_LOG2));
                r.vld = 1;
                samp.delete();
            end
        end
        r.temp = m_temp; r.fault = m_fault; r.err = m_err;
    endtask

    task automatic wait_ena();
        int k = 0;
        do begin @(negedge clk); k++; end while (!spi.ena && k < 300);
        if (!spi.ena) begin
            n_chk++; n_fail++;
            $display("FAIL ena_timeout: no o_ena within %0d cycles, expected one", k);
        end
    endtask

    task automatic txn(input logic [15:0] w, input int dly, input int trig_at);
        res_t r;
        fq.push_back('{w, dly});
        gq.push_back(next_gap);
        next_gap = PERIOD;
        model(w, dly, r);
        rq.push_back(r);
        wait_ena();
        if (trig_at > 0) begin
            repeat (trig_at) @(posedge clk);
            #1 trig = 1;
            @(posedge clk);
            #1 trig = 0;
            if (trig_at >= 40) next_gap = trig_at + 1;
        end
    endtask

    // behavioural SPI master: answers each start with a strobe dly cycles later, or none
    initial begin
        spi.wstb = 0;
        spi.wout = '0;
        forever begin
            @(negedge clk);
            if (spi.ena && fq.size() != 0) begin
                sf = fq.pop_front();
                if (sf.dly > 0) begin
                    repeat (sf.dly) @(posedge clk);
                    #1 spi.wout = sf.w;
                    spi.wstb = 1;
                    @(posedge clk);
                    #1 spi.wstb = 0;
                    spi.wout = 16'($urandom);
                end
            end
        end
    end

    // monitor: each start checks its spacing and the settled result of the previous frame
    always @(negedge clk) begin
        if (o_temp_vld) begin nv++; vt = o_temp; end
        if (spi.ena && sb_on) begin
            gp = (gq.size() != 0) ? gq.pop_front() : -1;
            check("start_gap", cyc - last_ena, gp);
            last_ena = cyc;
            if (!have_prev) begin
                check("idle_vld", nv, 0);
                check("idle_temp", o_temp, 0);
                check("idle_flags", {o_fault, o_frame_err}, 0);
            end else if (rq.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                mr = rq.pop_front();
                check("vld_count", nv, mr.vld);
                if (mr.vld != 0) check("avg_temp", vt, mr.temp);
                check("temp_hold", o_temp, mr.temp);
                check("fault", o_fault, mr.fault);
                check("frame_err", o_frame_err, mr.err);
            end
            have_prev = 1;
            nv = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int nv2, ga;
        rst = 1; trig = 0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_ena", spi.ena, 0);
        check("rst_win", spi.win, 0);
        check("rst_temp", o_temp, 0);
        check("rst_outs", {o_temp_vld, o_fault, o_frame_err}, 0);
        rst = 0; rel = cyc; last_ena = cyc;
        repeat (4) txn(16'h0C80, 34, 0);
        txn(16'h0C80, 34, 0); txn(16'h0C88, 34, 60); txn(16'h0C90, 34, 0); txn(16'h0C98, 34, 0);
        txn(16'h0C80, 34, 0); txn(16'h0C80, 34, 0); txn(16'h0004, 34, 0);
        repeat (4) txn(16'h0C80, 34, 0);
        txn(16'h0004, 34, 0); txn(16'h8000, 34, 0); txn(16'h0002, 34, 0);
        txn(16'h0C80, 0, 0); txn(16'h0C80, 64, 0); txn(16'h0C80, 65, 0); txn(16'h0C80, 20, 10);
        for (int i = 0; i < 60; i++) begin
            int c, d, t;
            logic [15:0] w;
            c = $urandom_range(0, 9); d = $urandom_range(1, 60); t = 0;
            w = 16'($urandom);
            if (c <= 5 || c == 9) begin
                w[15] = 0; w[2] = 0; w[1] = 0;
                if (c == 9) d = 64;
                else if (d <= 35 && $urandom_range(0, 3) == 0) t = $urandom_range(45, 90);
            end else if (c == 6) begin
                w[15] = 0; w[1] = 0; w[2] = 1;
            end else if (c == 7) begin
                if ($urandom_range(0, 1) == 1) w[15] = 1;
                else begin w[15] = 0; w[1] = 1; end
            end else d = ($urandom_range(0, 1) == 1) ? 0 : 65;
            txn(w, d, t);
        end
        txn(16'h8000, 34, 0);
        fq.push_back('{16'h0004, 40});
        gq.push_back(next_gap);
        wait_ena();
        #1 sb_on = 0;
        repeat (11) @(posedge clk);
        #1 rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0; rel = cyc;
        check("xrst_temp", o_temp, 0);
        check("xrst_outs", {o_temp_vld, o_fault, o_frame_err}, 0);
        nv2 = 0; ga = -1;
        for (int k = 0; k < 150 && ga < 0; k++) begin
            @(negedge clk);
            if (o_temp_vld) nv2++;
            if (spi.ena) ga = cyc - rel;
        end
        check("xrst_gap", ga, PERIOD);
        check("xrst_vld", nv2, 0);
        check("xrst_late_temp", o_temp, 0);
        check("xrst_late_flags", {o_fault, o_frame_err}, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
